// File: rtl/frame_dec_pkg.sv
// frame_dec_pkg: shared types/constants for the 21-bit Hamming frame decoder.
// Holds the FSM state enum, parity positions and the data extraction helper.
package frame_dec_pkg;

  localparam int DATA_W = 16;
  localparam int ENC_W  = 21;
  localparam int SYN_W  = 5;

  localparam int PARITY_IDX [SYN_W] = '{0, 1, 3, 7, 15};

  typedef enum logic [1:0] {
    S_B0,
    S_B1,
    S_B2
  } state_t;

  // Data bits occupy every non-parity index, packed in ascending order.
  function automatic logic [DATA_W-1:0] data_extract(
    input logic [ENC_W-1:0] cw
  );
    logic [DATA_W-1:0] d;
    logic              par;
    int                j;
    d = '0;
    j = 0;
    for (int k = 0; k < ENC_W; k++) begin
      par = 1'b0;
      for (int p = 0; p < SYN_W; p++) begin
        if (PARITY_IDX[p] == k) par = 1'b1;
      end
      if (!par) begin
        d[j[3:0]] = cw[k];
        j++;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_dec21.sv
// hamming_dec21: two-stage syndrome + single-bit correction pipeline.
// Ports: clk, rstb, i_cw/i_valid in; o_data, o_valid, o_corr, o_uncorr out.
import frame_dec_pkg::*;

module hamming_dec21 (
  input  logic              clk,
  input  logic              rstb,
  input  logic [ENC_W-1:0]  i_cw,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_corr,
  output logic              o_uncorr
);

  logic [SYN_W-1:0] w_syn;
  logic [ENC_W-1:0] r_s1_cw;
  logic [SYN_W-1:0] r_s1_syn;
  logic             r_s1_vld;
  logic             w_in_range;
  logic             w_over;
  logic [ENC_W-1:0] w_mask;
  logic [ENC_W-1:0] w_fix;

  always_comb begin
    w_syn = '0;
    for (int k = 0; k < ENC_W; k++) begin
      if (i_cw[k]) w_syn = w_syn ^ SYN_W'(k + 1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_s1_vld <= 1'b0;
      r_s1_cw  <= '0;
      r_s1_syn <= '0;
    end else begin
      r_s1_vld <= i_valid;
      if (i_valid) begin
        r_s1_cw  <= i_cw;
        r_s1_syn <= w_syn;
      end
    end
  end

  // Syndromes past the last codeword position cannot name a bit to fix.
  assign w_in_range = (r_s1_syn != '0) &&
                      (r_s1_syn <= SYN_W'(ENC_W));
  assign w_over     = (r_s1_syn > SYN_W'(ENC_W));
  assign w_mask     = w_in_range ?
                      (ENC_W'(1) << (r_s1_syn - SYN_W'(1))) : '0;
  assign w_fix      = r_s1_cw ^ w_mask;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_corr   <= 1'b0;
      o_uncorr <= 1'b0;
    end else begin
      o_valid <= r_s1_vld;
      if (r_s1_vld) begin
        o_data   <= data_extract(w_fix);
        o_corr   <= w_in_range;
        o_uncorr <= w_over;
      end
    end
  end

endmodule

// File: rtl/frame_decoder.sv
// frame_decoder: reassembles 3 UART bytes into a 21-bit Hamming codeword,
// with header check and inter-byte timeout, then decodes it via hamming_dec21.
// Ports: clk, rstb, byte_in, byte_valid -> data_out, data_valid,
// err_corrected, err_uncorrectable, frame_err.
// Optional macro FRAME_DEC_ERR_CNT_EN adds cnt_clr, corr_cnt, uncorr_cnt.
import frame_dec_pkg::*;

module frame_decoder #(
  parameter int DATA_WIDTH     = 16,
  parameter int ENC_WIDTH      = 21,
  parameter int TIMEOUT_CYCLES = 13020
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  err_corrected,
  output logic                  err_uncorrectable,
  output logic                  frame_err
`ifdef FRAME_DEC_ERR_CNT_EN
  ,
  input  logic                  cnt_clr,
  output logic [15:0]           corr_cnt,
  output logic [15:0]           uncorr_cnt
`endif
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_nxt_state;
  logic [TO_W-1:0]      r_to_cnt;
  logic [4:0]           r_b0;
  logic [7:0]           r_b1;
  logic [ENC_WIDTH-1:0] r_cw;
  logic                 r_cw_vld;
  logic                 r_frame_err;
  logic                 w_hdr_err;
  logic                 w_timeout;
  logic                 w_to_hit;
  logic                 w_cw_done;

  assign w_to_hit  = (r_to_cnt == TO_LAST);
  assign frame_err = r_frame_err;

  // A byte arriving on the timeout cycle takes priority over the timeout.
  always_comb begin
    w_nxt_state = r_state;
    w_hdr_err   = 1'b0;
    w_timeout   = 1'b0;
    w_cw_done   = 1'b0;
    unique case (r_state)
      S_B0: begin
        if (byte_valid) begin
          if (byte_in[7:5] != 3'b000) w_hdr_err = 1'b1;
          else w_nxt_state = S_B1;
        end
      end
      S_B1: begin
        if (byte_valid) begin
          w_nxt_state = S_B2;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_nxt_state = S_B0;
        end
      end
      S_B2: begin
        if (byte_valid) begin
          w_cw_done   = 1'b1;
          w_nxt_state = S_B0;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_nxt_state = S_B0;
        end
      end
      default: w_nxt_state = S_B0;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_B0;
      r_to_cnt    <= '0;
      r_frame_err <= 1'b0;
      r_b0        <= '0;
      r_b1        <= '0;
      r_cw        <= '0;
      r_cw_vld    <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_frame_err <= w_hdr_err | w_timeout;
      r_cw_vld    <= w_cw_done;
      if (r_state == S_B0 || byte_valid || w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (r_state == S_B0 && byte_valid && !w_hdr_err) begin
        r_b0 <= byte_in[4:0];
      end
      if (r_state == S_B1 && byte_valid) begin
        r_b1 <= byte_in;
      end
      if (w_cw_done) begin
        r_cw <= {r_b0, r_b1, byte_in};
      end
    end
  end

  hamming_dec21 u_dec (
    .clk      (clk),
    .rstb     (rstb),
    .i_cw     (r_cw),
    .i_valid  (r_cw_vld),
    .o_data   (data_out),
    .o_valid  (data_valid),
    .o_corr   (err_corrected),
    .o_uncorr (err_uncorrectable)
  );

`ifdef FRAME_DEC_ERR_CNT_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (data_valid && err_corrected && corr_cnt != 16'hFFFF) begin
        corr_cnt <= corr_cnt + 16'd1;
      end
      if (data_valid && err_uncorrectable &&
          uncorr_cnt != 16'hFFFF) begin
        uncorr_cnt <= uncorr_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_decoder.sv
// tb_frame_decoder: directed self-checking bench for frame_decoder.
// Hand-computed vectors; prints CHECKS/ERRORS summary.
module tb_frame_decoder;

  logic        clk;
  logic        rstb;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [15:0] data_out;
  logic        data_valid;
  logic        err_corrected;
  logic        err_uncorrectable;
  logic        frame_err;
`ifdef FRAME_DEC_ERR_CNT_EN
  logic        cnt_clr;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
`endif

  int n_chk;
  int n_err;
  int dv_cnt;
  int fe_cnt;

  frame_decoder dut (
    .clk               (clk),
    .rstb              (rstb),
    .byte_in           (byte_in),
    .byte_valid        (byte_valid),
    .data_out          (data_out),
    .data_valid        (data_valid),
    .err_corrected     (err_corrected),
    .err_uncorrectable (err_uncorrectable),
    .frame_err         (frame_err)
`ifdef FRAME_DEC_ERR_CNT_EN
    ,
    .cnt_clr           (cnt_clr),
    .corr_cnt          (corr_cnt),
    .uncorr_cnt        (uncorr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk or negedge rstb) begin
    if (!rstb) begin
      dv_cnt <= 0;
      fe_cnt <= 0;
    end else begin
      if (data_valid) dv_cnt <= dv_cnt + 1;
      if (frame_err)  fe_cnt <= fe_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference encoder: data in non-power-of-two positions, parity chosen
  // so the overall syndrome is zero.
  function automatic logic [20:0] enc(input logic [15:0] d);
    logic [20:0] cw;
    logic [4:0]  s;
    int          j;
    cw = '0;
    j  = 0;
    for (int k = 0; k < 21; k++) begin
      if (((k + 1) & k) != 0) begin
        cw[k] = d[j];
        j++;
      end
    end
    s = '0;
    for (int k = 0; k < 21; k++) if (cw[k]) s = s ^ 5'(k + 1);
    for (int b = 0; b < 5; b++) cw[(1 << b) - 1] = s[b];
    return cw;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [20:0] cw, input int gap,
                            input logic [15:0] ed, input logic ec,
                            input logic eu, input string tag);
    send_byte({3'b000, cw[20:16]}, gap);
    send_byte(cw[15:8], gap);
    @(negedge clk);
    byte_in    = cw[7:0];
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk({tag, "_dv_e0"}, 32'(data_valid), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_dv_e1"}, 32'(data_valid), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_dv_e2"}, 32'(data_valid), 32'd1);
    chk({tag, "_data"}, 32'(data_out), 32'(ed));
    chk({tag, "_corr"}, 32'(err_corrected), 32'(ec));
    chk({tag, "_uncorr"}, 32'(err_uncorrectable), 32'(eu));
    @(posedge clk);
    #1;
    chk({tag, "_dv_e3"}, 32'(data_valid), 32'd0);
    chk({tag, "_hold"}, 32'(data_out), 32'(ed));
  endtask

  logic [20:0] cw0;
  int          fe0;
  int          dv0;

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rstb       = 1'b0;
    byte_in    = '0;
    byte_valid = 1'b0;
`ifdef FRAME_DEC_ERR_CNT_EN
    cnt_clr    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_corr", 32'(err_corrected), 32'd0);
    chk("rst_uncorr", 32'(err_uncorrectable), 32'd0);
    chk("rst_fe", 32'(frame_err), 32'd0);

    cw0 = enc(16'h466b);
    fe0 = fe_cnt;
    send_frame(cw0, 4340, 16'h466b, 1'b0, 1'b0, "clean");
    chk("clean_no_fe", 32'(fe_cnt - fe0), 32'd0);

    send_frame(cw0 ^ (21'd1 << 10), 5, 16'h466b, 1'b1, 1'b0, "b10");
    // S=6 flips index 5 (d2) on top of d0,d1: data ^ 3'b111.
    send_frame(cw0 ^ (21'd1 << 2) ^ (21'd1 << 4), 5,
               16'h466c, 1'b1, 1'b0, "b2b4");
    // S=23 is out of range: raw data with d15 flipped.
    send_frame(cw0 ^ (21'd1 << 20) ^ (21'd1 << 1), 5,
               16'hc66b, 1'b0, 1'b1, "b20b1");

`ifdef FRAME_DEC_ERR_CNT_EN
    @(negedge clk);
    chk("cnt_corr", 32'(corr_cnt), 32'd2);
    chk("cnt_uncorr", 32'(uncorr_cnt), 32'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clr_corr", 32'(corr_cnt), 32'd0);
    chk("cnt_clr_uncorr", 32'(uncorr_cnt), 32'd0);
`endif

    fe0 = fe_cnt;
    dv0 = dv_cnt;
    @(negedge clk);
    byte_in    = 8'h25;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk("hdr_fe_pulse", 32'(frame_err), 32'd1);
    repeat (5) @(negedge clk);
    chk("hdr_fe_cnt", 32'(fe_cnt - fe0), 32'd1);
    chk("hdr_no_dv", 32'(dv_cnt - dv0), 32'd0);
    send_frame(enc(16'h1234), 3, 16'h1234, 1'b0, 1'b0, "post_hdr");

    cw0 = enc(16'hbeef);
    fe0 = fe_cnt;
    dv0 = dv_cnt;
    send_byte({3'b000, cw0[20:16]}, 2);
    send_byte(cw0[15:8], 2);
    repeat (13030) @(negedge clk);
    chk("to_fe_cnt", 32'(fe_cnt - fe0), 32'd1);
    chk("to_no_dv", 32'(dv_cnt - dv0), 32'd0);
    send_frame(cw0, 3, 16'hbeef, 1'b0, 1'b0, "post_to");

    // Byte lands on the exact timeout cycle: byte wins.
    cw0 = enc(16'h0f0f);
    fe0 = fe_cnt;
    send_byte({3'b000, cw0[20:16]}, 2);
    send_byte(cw0[15:8], 13018);
    send_byte(cw0[7:0], 4);
    chk("to_edge_no_fe", 32'(fe_cnt - fe0), 32'd0);
    chk("to_edge_data", 32'(data_out), 32'h0f0f);

    cw0 = enc(16'h5a5a);
    send_byte({3'b000, cw0[20:16]}, 2);
    send_byte(cw0[15:8], 2);
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    send_frame(enc(16'ha5c3), 3, 16'ha5c3, 1'b0, 1'b0, "post_rst");
    repeat (4) @(negedge clk);
    chk("post_rst_one_dv", 32'(dv_cnt), 32'd1);

    cw0 = enc(16'h7777);
    send_byte({3'b000, cw0[20:16]}, 2);
    send_byte(cw0[15:8], 2);
    @(negedge clk);
    byte_in    = cw0[7:0];
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    rstb       = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    repeat (6) @(negedge clk);
    chk("pipe_rst_no_dv", 32'(dv_cnt), 32'd0);
    chk("pipe_rst_data", 32'(data_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
